// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types for the fetch/decode hazard controller.
//   ctrl_state_e : controller FSM states
//   reg_idx_t    : 4-bit architectural register index
//   load_use_hit : true when the ID instruction reads the register a load in EX writes
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } ctrl_state_e;

  typedef logic [3:0] reg_idx_t;

  function automatic logic load_use_hit(
    input logic     mem_read,
    input reg_idx_t dest,
    input reg_idx_t src_a,
    input logic     use_a,
    input reg_idx_t src_b,
    input logic     use_b
  );
    return mem_read & ((use_a & (src_a == dest)) | (use_b & (src_b == dest)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard information from the pipeline and the control signals returned to it.
//   master : pipeline side, drives hazard inputs and consumes the enables/flushes
//   slave  : controller side, consumes hazard inputs and drives the enables/flushes
interface pipeline_hazard_controller_if;
  import pipeline_ctrl_pkg::*;

  logic     memBusy;
  logic     branchTaken_EX;
  logic     memRead_EX;
  reg_idx_t destReg_EX;
  reg_idx_t srcRegA_ID;
  reg_idx_t srcRegB_ID;
  logic     useA_ID;
  logic     useB_ID;
  logic     pcWriteEnable;
  logic     ifidWriteEnable;
  logic     ifidFlush;
  logic     idexFlush;

  modport master (
    output memBusy, branchTaken_EX, memRead_EX, destReg_EX,
           srcRegA_ID, srcRegB_ID, useA_ID, useB_ID,
    input  pcWriteEnable, ifidWriteEnable, ifidFlush, idexFlush
  );

  modport slave (
    input  memBusy, branchTaken_EX, memRead_EX, destReg_EX,
           srcRegA_ID, srcRegB_ID, useA_ID, useB_ID,
    output pcWriteEnable, ifidWriteEnable, ifidFlush, idexFlush
  );
endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush statistics.
//   clk, reset (sync, active-low), inc : count one event this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Front-end hazard controller: decides PC / IF/ID advance, hold or flush and
// ID/EX bubble injection. Priority: reset > memBusy > branch > load-use.
//   clk, reset (sync, active-low)
//   hz         : hazard inputs and control outputs (slave modport)
//   stallCount : cycles with ifidWriteEnable=0, saturating
//   flushCount : taken-branch events, saturating
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES    = 1,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_controller_if.slave hz,
  output logic [CNT_W-1:0]     stallCount,
  output logic [CNT_W-1:0]     flushCount
);

  localparam int MAX_CYC = (FLUSH_CYCLES > LOAD_USE_CYCLES) ? FLUSH_CYCLES : LOAD_USE_CYCLES;
  localparam int RW      = $clog2(MAX_CYC) + 1;

  ctrl_state_e   state, next_state;
  ctrl_state_e   saved_state, next_saved;
  ctrl_state_e   eff_state;
  logic [RW-1:0] remain, next_remain;
  logic          load_use;
  logic          pc_we, ifid_we, ifid_fl, idex_fl;
  logic          flush_inc, stall_inc;

  assign load_use = load_use_hit(hz.memRead_EX, hz.destReg_EX, hz.srcRegA_ID,
                                 hz.useA_ID, hz.srcRegB_ID, hz.useB_ID);

  // A freeze resumes the interrupted state's behaviour in the same cycle it ends.
  assign eff_state = (state == MEM_WAIT) ? saved_state : state;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_fl     = 1'b0;
    idex_fl     = 1'b0;
    flush_inc   = 1'b0;
    next_state  = state;
    next_saved  = saved_state;
    next_remain = remain;

    if (!reset) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else if (hz.memBusy) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      next_state = MEM_WAIT;
      if (state != MEM_WAIT) next_saved = state;
    end else begin
      case (eff_state)
        BR_FLUSH: begin
          // EX holds a bubble here, so branchTaken_EX is not looked at.
          ifid_fl     = 1'b1;
          idex_fl     = 1'b1;
          next_remain = remain - RW'(1);
          next_state  = (remain <= RW'(1)) ? RUN : BR_FLUSH;
        end
        default: begin
          if (hz.branchTaken_EX) begin
            // Also aborts any pending load stall.
            ifid_fl     = 1'b1;
            idex_fl     = 1'b1;
            flush_inc   = 1'b1;
            next_state  = (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
            next_remain = (FLUSH_CYCLES > 1) ? RW'(FLUSH_CYCLES - 1) : '0;
          end else if (eff_state == LOAD_STALL) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_fl     = 1'b1;
            next_remain = remain - RW'(1);
            next_state  = (remain <= RW'(1)) ? RUN : LOAD_STALL;
          end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_fl     = 1'b1;
            next_state  = (LOAD_USE_CYCLES > 1) ? LOAD_STALL : RUN;
            next_remain = (LOAD_USE_CYCLES > 1) ? RW'(LOAD_USE_CYCLES - 1) : '0;
          end else begin
            next_state = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      saved_state <= RUN;
      remain      <= '0;
    end else begin
      state       <= next_state;
      saved_state <= next_saved;
      remain      <= next_remain;
    end
  end

  assign stall_inc = ~ifid_we;

  assign hz.pcWriteEnable   = pc_we;
  assign hz.ifidWriteEnable = ifid_we;
  assign hz.ifidFlush       = ifid_fl;
  assign hz.idexFlush       = idex_fl;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .count (stallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .count (flushCount)
  );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;
  import pipeline_ctrl_pkg::*;

  localparam int FLUSH_CYCLES    = 2;
  localparam int LOAD_USE_CYCLES = 2;
  localparam int CNT_W           = 4;

  // {pcWE, ifidWE, ifidFlush, idexFlush}
  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1111;
  localparam logic [3:0] FRZ   = 4'b0000;
  localparam logic [3:0] RST   = 4'b0011;

  logic clk = 1'b0;
  logic reset;
  logic [CNT_W-1:0] stallCount, flushCount;

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller #(
    .FLUSH_CYCLES    (FLUSH_CYCLES),
    .LOAD_USE_CYCLES (LOAD_USE_CYCLES),
    .CNT_W           (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hz         (hz),
    .stallCount (stallCount),
    .flushCount (flushCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ctrl;
    int         sc;   // -1 = counters not checked
    int         fc;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // lu: 0 no load, 1 load-use hit on A, 2 matching reg but useA=0, 3 random
  task automatic vec(input bit rst_n, input bit mb, input bit br, input int lu,
                     input logic [3:0] ctrl, input int sc, input int fc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst_n;
    hz.memBusy        = mb;
    hz.branchTaken_EX = br;
    hz.srcRegB_ID     = 4'd5;
    hz.useB_ID        = 1'b0;
    case (lu)
      1: begin
        hz.memRead_EX = 1'b1; hz.destReg_EX = 4'd3; hz.srcRegA_ID = 4'd3; hz.useA_ID = 1'b1;
      end
      2: begin
        hz.memRead_EX = 1'b1; hz.destReg_EX = 4'd3; hz.srcRegA_ID = 4'd3; hz.useA_ID = 1'b0;
        hz.useB_ID = 1'b1;
      end
      3: begin
        hz.memBusy = 1'($urandom); hz.branchTaken_EX = 1'($urandom);
        hz.memRead_EX = 1'($urandom); hz.destReg_EX = 4'($urandom);
        hz.srcRegA_ID = 4'($urandom); hz.srcRegB_ID = 4'($urandom);
        hz.useA_ID = 1'($urandom); hz.useB_ID = 1'($urandom);
      end
      default: begin
        hz.memRead_EX = 1'b0; hz.destReg_EX = 4'd3; hz.srcRegA_ID = 4'd3; hz.useA_ID = 1'b1;
      end
    endcase
    e.ctrl = ctrl; e.sc = sc; e.fc = fc; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: outputs are Mealy, valid every cycle; sampled mid-cycle.
  initial begin
    exp_t e;
    logic [3:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {hz.pcWriteEnable, hz.ifidWriteEnable, hz.ifidFlush, hz.idexFlush};
        checks++;
        if (act !== e.ctrl ||
            (e.sc >= 0 && (int'(stallCount) != e.sc || int'(flushCount) != e.fc))) begin
          failures++;
          $display("FAIL %s: ctrl=%b stall=%0d flush=%0d, required ctrl=%b stall=%0d flush=%0d",
                   e.nm, act, stallCount, flushCount, e.ctrl, e.sc, e.fc);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    hz.memBusy = 1'b0; hz.branchTaken_EX = 1'b0; hz.memRead_EX = 1'b0;
    hz.destReg_EX = '0; hz.srcRegA_ID = '0; hz.srcRegB_ID = '0;
    hz.useA_ID = 1'b0; hz.useB_ID = 1'b0;

    // Reset with random hazard inputs
    vec(0, 0, 0, 3, RST, -1, 0, "reset_c1");
    vec(0, 0, 0, 3, RST, 0, 0, "reset_c2");
    vec(0, 0, 0, 3, RST, 0, 0, "reset_c3");
    vec(1, 0, 0, 0, NORM, 0, 0, "run_after_reset");

    // Load-use: exactly two bubble cycles
    vec(1, 0, 0, 1, STALL, 0, 0, "lu_c1");
    vec(1, 0, 0, 0, STALL, 1, 0, "lu_c2");
    vec(1, 0, 0, 0, NORM, 2, 0, "lu_done");
    vec(1, 0, 0, 2, NORM, 2, 0, "no_use_no_stall");
    vec(1, 0, 0, 0, NORM, 2, 0, "no_use_after");

    // Branch, two flush cycles
    vec(1, 0, 1, 0, FLUSH, 2, 0, "br_c1");
    vec(1, 0, 0, 0, FLUSH, 2, 1, "br_c2");
    vec(1, 0, 0, 0, NORM, 2, 1, "br_done");

    // Branch with load-use: branch wins, no stall
    vec(1, 0, 1, 1, FLUSH, 2, 1, "br_lu_c1");
    vec(1, 0, 0, 1, FLUSH, 2, 2, "br_lu_c2");
    vec(1, 0, 0, 0, NORM, 2, 2, "br_lu_done");

    // memBusy for 4 cycles inside BR_FLUSH
    vec(1, 0, 1, 0, FLUSH, 2, 2, "frz_br_c1");
    vec(1, 1, 1, 0, FRZ, 2, 3, "frz_1");
    vec(1, 1, 0, 0, FRZ, 3, 3, "frz_2");
    vec(1, 1, 0, 1, FRZ, 4, 3, "frz_3");
    vec(1, 1, 0, 0, FRZ, 5, 3, "frz_4");
    vec(1, 0, 0, 0, FLUSH, 6, 3, "frz_resume_flush");
    vec(1, 0, 0, 0, NORM, 6, 3, "frz_back_run");

    // memBusy together with branch: freeze, then service branch
    vec(1, 1, 1, 0, FRZ, 6, 3, "mb_br_frz");
    vec(1, 0, 1, 0, FLUSH, 7, 3, "mb_br_c1");
    vec(1, 0, 0, 0, FLUSH, 7, 4, "mb_br_c2");
    vec(1, 0, 0, 0, NORM, 7, 4, "mb_br_done");

    // Branch aborts a pending load stall
    vec(1, 0, 0, 1, STALL, 7, 4, "abort_lu");
    vec(1, 0, 1, 0, FLUSH, 8, 4, "abort_br_c1");
    vec(1, 0, 0, 0, FLUSH, 8, 5, "abort_br_c2");
    vec(1, 0, 0, 0, NORM, 8, 5, "abort_done");

    // Reset mid-flush leaves no residual bubble
    vec(1, 0, 1, 0, FLUSH, 8, 5, "mid_br");
    vec(0, 0, 0, 0, RST, 8, 6, "mid_reset");
    vec(1, 0, 0, 0, NORM, 0, 0, "mid_release");

    // 20 load-use stalls; stallCount must stick at 15
    for (int i = 0; i < 20; i++) begin
      vec(1, 0, 0, 1, STALL, (2*i > 15) ? 15 : 2*i, 0, "sat_a");
      vec(1, 0, 0, 0, STALL, (2*i+1 > 15) ? 15 : 2*i+1, 0, "sat_b");
    end
    vec(1, 0, 0, 0, NORM, 15, 0, "sat_hold");

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
